// File: rtl/reg_file_32x.sv
// reg_file_32x: 32 x N register file with R0 hardwired to zero, one write port,
// two registered read ports and a sequenced clear engine. Optional macro: REGFILE_BYPASS_EN.

module reg_file_mux32 #(
    parameter int N = 32
) (
    input  logic [32*N-1:0] data_i,
    input  logic [4:0]      sel_i,
    output logic [N-1:0]    data_o
);

    // Pick the N-bit lane addressed by sel_i out of the flattened array
    always_comb begin
        data_o = {N{1'b0}};
        for (int i = 0; i < 32; i++) begin
            if (sel_i == 5'(i)) begin
                data_o = data_i[i*N +: N];
            end else begin
                data_o = data_o;
            end
        end
    end

endmodule

module reg_file_32x #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [4:0]   waddr_i,
    input  logic [N-1:0] wdata_i,
    input  logic         re_i,
    input  logic [4:0]   raddr_a_i,
    input  logic [4:0]   raddr_b_i,
    output logic [N-1:0] rdata_a_o,
    output logic [N-1:0] rdata_b_o,
    output logic         rvalid_o,
    input  logic         clr_start_i,
    output logic         busy_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:1][N-1:0] regs_q, regs_d;
    logic [N-1:0]      rdata_a_q, rdata_a_d;
    logic [N-1:0]      rdata_b_q, rdata_b_d;
    logic              rvalid_q;
    logic              busy_q, busy_d;
    logic [N-1:0]      mux_a_s, mux_b_s;
    logic [32*N-1:0]   regs_flat_s;
    logic              wr_en_s;

    // R0 is not stored; its lane in the read mux is a constant zero
    assign regs_flat_s = {regs_q, {N{1'b0}}};

    reg_file_mux32 #(.N(N)) u_mux_a (
        .data_i (regs_flat_s),
        .sel_i  (raddr_a_i),
        .data_o (mux_a_s)
    );

    reg_file_mux32 #(.N(N)) u_mux_b (
        .data_i (regs_flat_s),
        .sel_i  (raddr_b_i),
        .data_o (mux_b_s)
    );

    // A write commits only in IDLE, when no clear is starting, and never to R0
    always_comb begin
        wr_en_s = (state_q == ST_IDLE) && we_i && !clr_start_i && (waddr_i != 5'd0);
    end

    // Clear FSM next state and array update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = 5'd1;
                end else if (wr_en_s) begin
                    for (int i = 1; i < 32; i++) begin
                        if (waddr_i == 5'(i)) begin
                            regs_d[i] = wdata_i;
                        end else begin
                            regs_d[i] = regs_q[i];
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                for (int i = 1; i < 32; i++) begin
                    if (cnt_q == 5'(i)) begin
                        regs_d[i] = {N{1'b0}};
                    end else begin
                        regs_d[i] = regs_q[i];
                    end
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Read data capture; holds when re_i is low
    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re_i) begin
            rdata_a_d = mux_a_s;
            rdata_b_d = mux_b_s;
`ifdef REGFILE_BYPASS_EN
            if (wr_en_s && (raddr_a_i == waddr_i)) begin
                rdata_a_d = wdata_i;
            end else begin
                rdata_a_d = mux_a_s;
            end
            if (wr_en_s && (raddr_b_i == waddr_i)) begin
                rdata_b_d = wdata_i;
            end else begin
                rdata_b_d = mux_b_s;
            end
`endif
        end else begin
            rdata_a_d = rdata_a_q;
            rdata_b_d = rdata_b_q;
        end
    end

    // State, array and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            regs_q    <= {(31*N){1'b0}};
            rdata_a_q <= {N{1'b0}};
            rdata_b_q <= {N{1'b0}};
            rvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            regs_q    <= regs_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rvalid_q  <= re_i;
            busy_q    <= busy_d;
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
    assign rvalid_o  = rvalid_q;
    assign busy_o    = busy_q;

endmodule
